// File: rtl/jtdsp16_cache.sv
// jtdsp16_cache: do-loop instruction cache for the DSP16 core.
//
// A "do K {NI}" captures the next NI instruction words as they are fetched
// from ROM. The cache then replays them K-1 more times while the XAAU holds
// the PC. A "redo K" (NI=0) replays the last captured body K times.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   cen        clock enable; all state advances only when high
//   do_start   one-cen pulse: do/redo decoded
//   do_data    [10:7]=NI (0 means redo), [6:0]=K iteration count
//   pc_adv     current rom_dout word consumed by the decoder this cycle
//   stall      decoder holding the current instruction; freezes replay
//   rom_dout   word from program ROM
//   inst_dout  word to the decoder (cache word while replaying)
//   cache_rd   replay active; XAAU must hold the PC
//   busy       load or replay active
//   no_int     interrupts blocked (same as busy)
//   done       one-cen pulse when a loop completes
//   iter_left  remaining iterations including the current one; 0 when idle

module jtdsp16_cache #(
  parameter int unsigned DEPTH = 15,
  parameter int unsigned AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        do_start,
  input  logic [10:0] do_data,
  input  logic        pc_adv,
  input  logic        stall,
  input  logic [15:0] rom_dout,
  output logic [15:0] inst_dout,
  output logic        cache_rd,
  output logic        busy,
  output logic        no_int,
  output logic        done,
  output logic [6:0]  iter_left
);

  typedef enum logic [1:0] {StIdle, StLoad, StReplay} state_e;

  state_e          r_state, w_state_d;
  logic [AW-1:0]   r_widx, w_widx_d;
  logic [AW-1:0]   r_ridx, w_ridx_d;
  logic [6:0]      r_iter, w_iter_d;
  logic [3:0]      r_last_ni, w_last_ni_d;
  logic            r_done, w_done_d;
  logic            w_mem_we;
  logic [15:0]     r_mem [DEPTH];

  logic [3:0]      w_ni;
  logic [6:0]      w_k;
  logic [AW-1:0]   w_last_idx;
  logic            w_last_iter;

  assign w_ni        = do_data[10:7];
  // K=0 behaves as a single pass
  assign w_k         = (do_data[6:0] == 7'd0) ? 7'd1 : do_data[6:0];
  assign w_last_idx  = AW'(r_last_ni) - AW'(1);
  assign w_last_iter = (r_iter == 7'd1);

  always_comb begin
    w_state_d   = r_state;
    w_widx_d    = r_widx;
    w_ridx_d    = r_ridx;
    w_iter_d    = r_iter;
    w_last_ni_d = r_last_ni;
    w_done_d    = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      StIdle: begin
        if (do_start) begin
          if (w_ni != 4'd0) begin
            w_state_d   = StLoad;
            w_widx_d    = '0;
            w_iter_d    = w_k;
            w_last_ni_d = w_ni;
          end else if (r_last_ni == 4'd0) begin
            // redo with nothing captured: complete immediately
            w_done_d = 1'b1;
          end else begin
            w_state_d = StReplay;
            w_ridx_d  = '0;
            w_iter_d  = w_k;
          end
        end
      end
      StLoad: begin
        if (pc_adv) begin
          w_mem_we = 1'b1;
          w_widx_d = r_widx + AW'(1);
          if (r_widx == w_last_idx) begin
            if (w_last_iter) begin
              w_state_d = StIdle;
              w_done_d  = 1'b1;
              w_iter_d  = 7'd0;
            end else begin
              w_state_d = StReplay;
              w_ridx_d  = '0;
              w_iter_d  = r_iter - 7'd1;
            end
          end
        end
      end
      StReplay: begin
        if (!stall) begin
          if (r_ridx == w_last_idx) begin
            w_ridx_d = '0;
            if (w_last_iter) begin
              w_state_d = StIdle;
              w_done_d  = 1'b1;
              w_iter_d  = 7'd0;
            end else begin
              w_iter_d = r_iter - 7'd1;
            end
          end else begin
            w_ridx_d = r_ridx + AW'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_widx    <= '0;
      r_ridx    <= '0;
      r_iter    <= 7'd0;
      r_last_ni <= 4'd0;
      r_done    <= 1'b0;
    end else if (cen) begin
      r_state   <= w_state_d;
      r_widx    <= w_widx_d;
      r_ridx    <= w_ridx_d;
      r_iter    <= w_iter_d;
      r_last_ni <= w_last_ni_d;
      r_done    <= w_done_d;
    end
  end

  // Storage is not reset; a cleared last_ni makes stale contents unreachable
  always_ff @(posedge clk) begin
    if (!rst && cen && w_mem_we) begin
      r_mem[r_widx] <= rom_dout;
    end
  end

  assign cache_rd  = (r_state == StReplay);
  assign busy      = (r_state != StIdle);
  assign no_int    = busy;
  assign done      = r_done;
  assign iter_left = r_iter;
  assign inst_dout = cache_rd ? r_mem[r_ridx] : rom_dout;

endmodule

// File: tb/tb_jtdsp16_cache.sv
module tb_jtdsp16_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        do_start;
  logic [10:0] do_data;
  logic        pc_adv;
  logic        stall;
  logic [15:0] rom_dout;
  logic [15:0] inst_dout;
  logic        cache_rd;
  logic        busy;
  logic        no_int;
  logic        done;
  logic [6:0]  iter_left;

  int checks   = 0;
  int failures = 0;

  jtdsp16_cache #(.DEPTH(15), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .do_start  (do_start),
    .do_data   (do_data),
    .pc_adv    (pc_adv),
    .stall     (stall),
    .rom_dout  (rom_dout),
    .inst_dout (inst_dout),
    .cache_rd  (cache_rd),
    .busy      (busy),
    .no_int    (no_int),
    .done      (done),
    .iter_left (iter_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_rd;
    int n_bad;
    int n_done;
    logic [15:0] exp_w [4];

    rst = 1'b1; cen = 1'b0; do_start = 1'b0; do_data = '0;
    pc_adv = 1'b0; stall = 1'b0; rom_dout = 16'hABCD;
    cyc(); cyc();
    // reset state (with cen low)
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cache_rd", 32'(cache_rd), 32'd0);
    chk("rst_iter", 32'(iter_left), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_inst", 32'(inst_dout), 32'hABCD);
    rst = 1'b0; cen = 1'b1;

    // redo right after reset: nothing captured
    do_start = 1'b1; do_data = 11'h002; #1;
    cyc(); do_start = 1'b0; #1;
    chk("redo0_busy", 32'(busy), 32'd0);
    chk("redo0_done", 32'(done), 32'd1);
    chk("redo0_inst", 32'(inst_dout), 32'hABCD);
    cyc();
    chk("redo0_done_clr", 32'(done), 32'd0);

    // do NI=2 K=3
    do_start = 1'b1; do_data = {4'd2, 7'd3};
    cyc(); do_start = 1'b0;
    rom_dout = 16'h1111; pc_adv = 1'b1; #1;
    chk("d1_l0_busy", 32'(busy), 32'd1);
    chk("d1_l0_rd", 32'(cache_rd), 32'd0);
    chk("d1_l0_iter", 32'(iter_left), 32'd3);
    chk("d1_l0_inst", 32'(inst_dout), 32'h1111);
    cyc();
    rom_dout = 16'h2222; #1;
    chk("d1_l1_inst", 32'(inst_dout), 32'h2222);
    chk("d1_l1_iter", 32'(iter_left), 32'd3);
    cyc();
    pc_adv = 1'b0; rom_dout = 16'hDEAD;
    exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h1111; exp_w[3] = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("d1_r%0d_inst", i), 32'(inst_dout), 32'(exp_w[i]));
      chk($sformatf("d1_r%0d_rd", i), 32'(cache_rd), 32'd1);
      chk($sformatf("d1_r%0d_iter", i), 32'(iter_left), (i < 2) ? 32'd2 : 32'd1);
      chk($sformatf("d1_r%0d_done", i), 32'(done), 32'd0);
      cyc();
    end
    chk("d1_end_done", 32'(done), 32'd1);
    chk("d1_end_busy", 32'(busy), 32'd0);
    chk("d1_end_rd", 32'(cache_rd), 32'd0);
    chk("d1_end_iter", 32'(iter_left), 32'd0);
    chk("d1_end_inst", 32'(inst_dout), 32'hDEAD);
    cyc();
    chk("d1_done_clr", 32'(done), 32'd0);

    // redo K=2 reuses the 2-word body
    do_start = 1'b1; do_data = 11'h002;
    cyc(); do_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rd_r%0d_inst", i), 32'(inst_dout), 32'(exp_w[i]));
      chk($sformatf("rd_r%0d_rd", i), 32'(cache_rd), 32'd1);
      chk($sformatf("rd_r%0d_iter", i), 32'(iter_left), (i < 2) ? 32'd2 : 32'd1);
      cyc();
    end
    chk("rd_end_done", 32'(done), 32'd1);
    chk("rd_end_rd", 32'(cache_rd), 32'd0);
    cyc();

    // do NI=3 K=2 with load holds, cen gaps and replay stalls
    do_start = 1'b1; do_data = {4'd3, 7'd2};
    cyc(); do_start = 1'b0;
    rom_dout = 16'hA001; pc_adv = 1'b1; cyc();
    rom_dout = 16'hFFFF; pc_adv = 1'b0; cyc();
    rom_dout = 16'hA002; pc_adv = 1'b1; cyc();
    rom_dout = 16'hA003; cen = 1'b0; cyc();
    #1;
    chk("d2_cen0_rd", 32'(cache_rd), 32'd0);
    cen = 1'b1; cyc();
    pc_adv = 1'b0; rom_dout = 16'h0BAD;
    // nested do while busy is ignored
    do_start = 1'b1; do_data = {4'd2, 7'd3}; #1;
    chk("d2_r1_inst", 32'(inst_dout), 32'hA001);
    chk("d2_r1_iter", 32'(iter_left), 32'd1);
    cyc(); do_start = 1'b0;
    stall = 1'b1; #1;
    chk("d2_r2a_inst", 32'(inst_dout), 32'hA002);
    cyc(); #1;
    chk("d2_r2b_inst", 32'(inst_dout), 32'hA002);
    cyc(); stall = 1'b0; cen = 1'b0; #1;
    chk("d2_r2c_inst", 32'(inst_dout), 32'hA002);
    cyc(); cen = 1'b1; #1;
    chk("d2_r2d_inst", 32'(inst_dout), 32'hA002);
    chk("d2_r2d_rd", 32'(cache_rd), 32'd1);
    cyc(); #1;
    chk("d2_r3_inst", 32'(inst_dout), 32'hA003);
    chk("d2_r3_done", 32'(done), 32'd0);
    cyc();
    chk("d2_end_done", 32'(done), 32'd1);
    chk("d2_end_busy", 32'(busy), 32'd0);
    cen = 1'b0; cyc();
    chk("d2_done_hold", 32'(done), 32'd1);
    cen = 1'b1; cyc();
    chk("d2_done_clr", 32'(done), 32'd0);

    // K=0 behaves as K=1: single load pass, no replay
    do_start = 1'b1; do_data = {4'd1, 7'd0};
    cyc(); do_start = 1'b0;
    rom_dout = 16'h7777; pc_adv = 1'b1; #1;
    chk("k0_iter", 32'(iter_left), 32'd1);
    cyc(); pc_adv = 1'b0; #1;
    chk("k0_done", 32'(done), 32'd1);
    chk("k0_rd", 32'(cache_rd), 32'd0);
    cyc();

    // do NI=15 K=127
    do_start = 1'b1; do_data = {4'd15, 7'd127};
    cyc(); do_start = 1'b0; pc_adv = 1'b1;
    for (int i = 0; i < 15; i++) begin
      rom_dout = 16'h5000 + 16'(i);
      cyc();
    end
    pc_adv = 1'b0; rom_dout = 16'hBEEF; #1;
    chk("big_iter0", 32'(iter_left), 32'd126);
    n_rd = 0; n_bad = 0; n_done = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        n_done++;
        break;
      end
      if (!cache_rd || !no_int) n_bad++;
      else if (inst_dout !== 16'h5000 + 16'(n_rd % 15)) n_bad++;
      n_rd++;
      cyc();
    end
    chk("big_rd_cycles", 32'(n_rd), 32'd1890);
    chk("big_bad", 32'(n_bad), 32'd0);
    chk("big_done", 32'(n_done), 32'd1);
    chk("big_end_noint", 32'(no_int), 32'd0);
    cyc();
    chk("big_done_clr", 32'(done), 32'd0);

    // reset mid-replay
    do_start = 1'b1; do_data = {4'd2, 7'd3};
    cyc(); do_start = 1'b0; pc_adv = 1'b1;
    rom_dout = 16'h3333; cyc();
    rom_dout = 16'h4444; cyc();
    pc_adv = 1'b0; rom_dout = 16'h9999; #1;
    chk("mr_rd", 32'(cache_rd), 32'd1);
    cyc(); rst = 1'b1; cyc(); rst = 1'b0; #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_rd0", 32'(cache_rd), 32'd0);
    chk("mr_iter", 32'(iter_left), 32'd0);
    chk("mr_inst", 32'(inst_dout), 32'h9999);
    do_start = 1'b1; do_data = 11'h002;
    cyc(); do_start = 1'b0; #1;
    chk("mr_redo_busy", 32'(busy), 32'd0);
    chk("mr_redo_done", 32'(done), 32'd1);
    cyc();
    chk("mr_redo_busy2", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtdsp16_cache.md
Name: jtdsp16_cache

Overview:
- Do-loop instruction cache for the DSP16 core. It sits between program ROM/XAAU fetch and the instruction decoder.
- On a `do K {NI}` or `redo K` decoded by the controller, it captures the next NI instruction words as they are fetched from ROM. It then replays them from internal storage K-1 more times.
- While replaying it supplies instruction words to the decoder and tells the XAAU to freeze the PC.

Parameters:
- DEPTH, 15, maximum loop body length in words (NI field max).
- AW, 4, cache index width; must satisfy 2^AW > DEPTH.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- cen  input  1  clock enable; all state advances only when cen=1.
- do_start  input  1  one-cen pulse from decoder: do/redo decoded.
- do_data  input  11  [10:7]=NI (0 means redo), [6:0]=K iteration count.
- pc_adv  input  1  current rom_dout word is consumed by decoder this cen cycle (PC advanced).
- stall  input  1  decoder holding current instruction (multi-cycle op); freezes replay index.
- rom_dout  input  16  word from program ROM.
- inst_dout  output  16  instruction word to decoder: rom_dout when not replaying, cache word when replaying.
- cache_rd  output  1  replay active; XAAU must hold PC and not fetch.
- busy  output  1  LOAD or REPLAY active.
- no_int  output  1  =busy; interrupts blocked inside loops.
- done  output  1  one-cen pulse when loop completes.
- iter_left  output  7  remaining iterations including current one; 0 when idle.

Behaviour:
- Reset (sync, rst=1 at clk edge, regardless of cen):
  - state=IDLE; widx, ridx, iter_left, last_ni, done, cache_rd, busy all 0.
  - Memory contents are not cleared.
- inst_dout is combinational: cache_rd ? mem[ridx] : rom_dout.
  - Memory is a register file with asynchronous read and write on cen.
- K normalisation: K=0 is treated as K=1.
- State IDLE:
  - do_start with NI>0: next state LOAD; widx=0; iter_left=K; last_ni=NI.
  - do_start with NI=0 (redo):
    - If last_ni=0: stay IDLE and pulse done next cycle.
    - Else: REPLAY with ridx=0 and iter_left=K.
- State LOAD (cache_rd=0, busy=1):
  - Each cen with pc_adv=1: mem[widx]<=rom_dout; widx++.
  - When the word written is at widx=last_ni-1:
    - If iter_left==1: go to IDLE, done=1, iter_left=0.
    - Else: go to REPLAY, ridx=0, iter_left--.
  - pc_adv=0 holds widx.
- State REPLAY (cache_rd=1, busy=1):
  - Each cen with stall=0: ridx++.
  - At ridx=last_ni-1:
    - If iter_left==1: go to IDLE, done=1, cache_rd deasserts next cycle, iter_left=0.
    - Else: ridx=0, iter_left--.
  - stall=1 holds ridx and iter_left.
- done is high for exactly one cen cycle; it is cleared on the next cen.
- do_start while busy=1 is ignored; nested loops are illegal.
- last_ni survives loop completion so redo reuses the last body. It is only overwritten by a new do with NI>0.
- NI>DEPTH cannot occur (4-bit field; DEPTH=15).
- Latency: first cache word appears on inst_dout in the cen cycle after the last loaded word is captured.

Test Plan:
- do NI=2 K=3; ROM words 0x1111, 0x2222 with pc_adv → inst_dout sequence 0x1111, 0x2222, 0x1111, 0x2222, 0x1111, 0x2222. cache_rd=1 for the last 4 cycles; done pulses once after the final 0x2222; iter_left counts 3, 2, 1, 0.
- Then redo (do_data=0x002, NI=0 K=2), no pc_adv → inst_dout 0x1111, 0x2222, 0x1111, 0x2222 from cache; cache_rd=1 for 4 cycles; done after.
- Redo immediately after reset (last_ni=0) → busy never asserts; done pulses one cycle later; inst_dout tracks rom_dout.
- do NI=3 K=2 with stall=1 for 2 cycles on the 2nd replayed word → that word held on inst_dout for 3 cen cycles. Total replay length is 5 cen cycles. cen=0 cycles also freeze all state.
- do NI=15 K=127 → 15 LOAD writes, then 126 replays of 15 words (1890 cache_rd cycles). no_int=1 throughout; single done.
- rst=1 mid-REPLAY → next cycle busy=0, cache_rd=0, iter_left=0, inst_dout=rom_dout; a following redo does nothing (last_ni cleared).
